// File: rtl/pc_sequencer_pkg.sv
// Shared phase codes, opcodes and default widths for the 2-bit computer sequencer.
package pc_sequencer_pkg;

  localparam int DEF_PC_W = 2;
  localparam int DEF_OP_W = 2;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_FETCH = 2'd1,
    PH_EXEC  = 2'd2,
    PH_HALT  = 2'd3
  } phase_t;

  typedef logic [DEF_OP_W-1:0] opcode_t;

  localparam opcode_t OP_LDA = 2'b00;
  localparam opcode_t OP_ADD = 2'b01;
  localparam opcode_t OP_JZ  = 2'b10;
  localparam opcode_t OP_HLT = 2'b11;

  // Opcodes that write the accumulator.
  function automatic logic is_acc_op(input opcode_t op);
    return (op == OP_LDA) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/pc_sequencer_pc_counter.sv
// Program counter register: async reset, parallel load (priority) and increment.
module pc_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  // Load beats increment; the counter wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (inc) begin
      q <= q + W'(1);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC / IR / FETCH-EXEC phase machine with Moore accumulator strobes.
// Optional macro SINGLE_STEP_EN adds a Step input gating each instruction.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int OP_W = DEF_OP_W
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Run,
`ifdef SINGLE_STEP_EN
  input  logic                 Step,
`endif
  input  logic [OP_W+PC_W-1:0] Instr,
  input  logic                 Zero,
  output logic [PC_W-1:0]      Pc,
  output logic [1:0]           Phase,
  output logic                 IR_Load,
  output logic                 Acc_Load,
  output logic                 Acc_Src,
  output logic                 Halted
);

  phase_t                 state;
  logic [OP_W+PC_W-1:0]   ir;
  opcode_t                ir_op;
  opcode_t                fetch_op;
  logic                   go;
  logic                   resume;
  logic                   pc_inc;
  logic                   pc_load;
  logic                   ir_load_q;
  logic                   acc_load_q;
  logic                   acc_src_q;
  logic                   halted_q;

  assign ir_op    = opcode_t'(ir[PC_W +: OP_W]);
  assign fetch_op = opcode_t'(Instr[PC_W +: OP_W]);

`ifdef SINGLE_STEP_EN
  logic step_q;

  // Edge detect on Step so a held button releases only one instruction.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= Step;
    end
  end

  assign go     = Run & Step & ~step_q;
  assign resume = 1'b0;
`else
  assign go     = Run;
  assign resume = Run;
`endif

  assign pc_inc  = (state == PH_FETCH);
  assign pc_load = (state == PH_EXEC) && (ir_op == OP_JZ) && Zero;

  pc_counter #(.W(PC_W)) u_pc (
    .clk  (CLK),
    .rst  (Reset),
    .inc  (pc_inc),
    .load (pc_load),
    .din  (ir[PC_W-1:0]),
    .q    (Pc)
  );

  // Phase machine; strobes are set for the state being entered so they track it exactly.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= PH_IDLE;
      ir         <= '0;
      ir_load_q  <= 1'b0;
      acc_load_q <= 1'b0;
      acc_src_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state)
        PH_IDLE: begin
          if (go) begin
            state     <= PH_FETCH;
            ir_load_q <= 1'b1;
          end
        end
        PH_FETCH: begin
          state      <= PH_EXEC;
          ir         <= Instr;
          ir_load_q  <= 1'b0;
          acc_load_q <= is_acc_op(fetch_op);
          acc_src_q  <= (fetch_op == OP_ADD);
        end
        PH_EXEC: begin
          acc_load_q <= 1'b0;
          acc_src_q  <= 1'b0;
          if (ir_op == OP_HLT) begin
            state    <= PH_HALT;
            halted_q <= 1'b1;
          end else if (resume) begin
            state     <= PH_FETCH;
            ir_load_q <= 1'b1;
          end else begin
            state <= PH_IDLE;
          end
        end
        PH_HALT: begin
          state <= PH_HALT;
        end
        default: begin
          state <= PH_IDLE;
        end
      endcase
    end
  end

  assign Phase    = state;
  assign IR_Load  = ir_load_q;
  assign Acc_Load = acc_load_q;
  assign Acc_Src  = acc_src_q;
  assign Halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: instruction-level model compared every cycle plus directed literal checks.
module tb_pc_sequencer;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic       Run;
  logic       Zero;
  logic [3:0] Instr;
  logic [1:0] Pc;
  logic [1:0] Phase;
  logic       IR_Load, Acc_Load, Acc_Src, Halted;
`ifdef SINGLE_STEP_EN
  logic       Step;
`endif

  logic [3:0] prog [4];
  int checks = 0;
  int errors = 0;

  assign Instr = prog[Pc];

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Run      (Run),
`ifdef SINGLE_STEP_EN
    .Step     (Step),
`endif
    .Instr    (Instr),
    .Zero     (Zero),
    .Pc       (Pc),
    .Phase    (Phase),
    .IR_Load  (IR_Load),
    .Acc_Load (Acc_Load),
    .Acc_Src  (Acc_Src),
    .Halted   (Halted)
  );

  // Model: phase 0 idle, 1 fetch, 2 exec, 3 halt; instruction {op[3:2], operand[1:0]}.
  int         m_phase;
  logic [1:0] m_pc;
  logic [3:0] m_ir;
  logic       m_go;
  logic       m_cont;
`ifdef SINGLE_STEP_EN
  logic       m_stepq;
  assign m_go   = Run & Step & ~m_stepq;
  assign m_cont = 1'b0;
`else
  assign m_go   = Run;
  assign m_cont = Run;
`endif

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      m_phase <= 0;
      m_pc    <= 2'd0;
      m_ir    <= 4'd0;
`ifdef SINGLE_STEP_EN
      m_stepq <= 1'b0;
`endif
    end else begin
`ifdef SINGLE_STEP_EN
      m_stepq <= Step;
`endif
      if (m_phase == 0) begin
        if (m_go) m_phase <= 1;
      end else if (m_phase == 1) begin
        m_ir    <= prog[m_pc];
        m_pc    <= m_pc + 2'd1;
        m_phase <= 2;
      end else if (m_phase == 2) begin
        if (m_ir[3:2] == 2'b10 && Zero) m_pc <= m_ir[1:0];
        if (m_ir[3:2] == 2'b11) m_phase <= 3;
        else m_phase <= m_cont ? 1 : 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("model_phase", 32'(Phase), 32'(m_phase));
    chk("model_pc", 32'(Pc), 32'(m_pc));
    chk("model_ir_load", 32'(IR_Load), 32'(m_phase == 1));
    chk("model_acc_load", 32'(Acc_Load), 32'(m_phase == 2 && m_ir[3] == 1'b0));
    chk("model_acc_src", 32'(Acc_Src), 32'(m_phase == 2 && m_ir[3:2] == 2'b01));
    chk("model_halted", 32'(Halted), 32'(m_phase == 3));
  end

  task automatic wait_model(input int ph, input logic [1:0] pc, input int budget);
    int n;
    n = 0;
    while (!(m_phase == ph && m_pc == pc) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!(m_phase == ph && m_pc == pc)) begin
      errors++;
      $display("FAIL wait_phase%0d_pc%0d: timed out, phase %0d pc %0d", ph, pc, m_phase, m_pc);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  int exp_seq [9] = '{1, 2, 1, 2, 1, 2, 1, 2, 3};
  logic [1:0] pc_hold;
  int exec_cnt;

  initial begin
    Run = 1'b0;
    Zero = 1'b0;
`ifdef SINGLE_STEP_EN
    Step = 1'b0;
`endif
    prog[0] = 4'b0001;  // LDA 1
    prog[1] = 4'b0110;  // ADD 2
    prog[2] = 4'b1000;  // JZ 0
    prog[3] = 4'b1100;  // HLT
    #1 Reset = 1'b1;
    repeat (2) @(negedge CLK);
    chk("reset_pc", 32'(Pc), 32'd0);
    chk("reset_phase", 32'(Phase), 32'd0);
    chk("reset_strobes", {28'd0, IR_Load, Acc_Load, Acc_Src, Halted}, 32'd0);
    Reset = 1'b0;

`ifndef SINGLE_STEP_EN
    // Full program, Zero=0.
    Run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      chk("seq_phase", 32'(Phase), 32'(exp_seq[i]));
      if (i == 1) chk("lda_strobes", {30'd0, Acc_Load, Acc_Src}, 32'd2);
      if (i == 3) chk("add_strobes", {30'd0, Acc_Load, Acc_Src}, 32'd3);
    end
    chk("prog_halted", 32'(Halted), 32'd1);
    chk("prog_pc_wrap", 32'(Pc), 32'd0);

    // Async reset mid-EXEC of ADD (Pc=2).
    do_reset();
    wait_model(2, 2'd2, 20);
    #2 Reset = 1'b1;
    #1;
    chk("async_pc", 32'(Pc), 32'd0);
    chk("async_phase", 32'(Phase), 32'd0);
    chk("async_strobes", {28'd0, IR_Load, Acc_Load, Acc_Src, Halted}, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    chk("post_reset_fetch_pc", 32'(Pc), 32'd0);

    // JZ 0 taken with Zero=1 loops forever.
    Zero = 1'b1;
    wait_model(2, 2'd3, 20);
    @(negedge CLK);
    chk("jz_taken_pc", 32'(Pc), 32'd0);
    chk("jz_taken_phase", 32'(Phase), 32'd1);
    repeat (20) @(negedge CLK);
    chk("jz_loop_not_halted", 32'(Halted), 32'd0);

    // JZ to its own address.
    prog[2] = 4'b1010;
    do_reset();
    wait_model(2, 2'd3, 20);
    @(negedge CLK);
    chk("jz_self_pc", 32'(Pc), 32'd2);
    repeat (2) @(negedge CLK);
    chk("jz_self_pc_again", 32'(Pc), 32'd2);
    chk("jz_self_phase", 32'(Phase), 32'd1);
    prog[2] = 4'b1000;

    // Drop Run during FETCH of address 1.
    Zero = 1'b0;
    do_reset();
    wait_model(1, 2'd1, 20);
    Run = 1'b0;
    @(negedge CLK);
    chk("drop_run_exec", 32'(Phase), 32'd2);
    @(negedge CLK);
    chk("drop_run_idle", 32'(Phase), 32'd0);
    chk("drop_run_pc", 32'(Pc), 32'd2);
    repeat (3) @(negedge CLK);
    chk("idle_hold", 32'(Phase), 32'd0);
    Run = 1'b1;
    @(negedge CLK);
    chk("resume_phase", 32'(Phase), 32'd1);
    chk("resume_pc", 32'(Pc), 32'd2);

    // HALT ignores Run and Zero.
    wait_model(3, 2'd0, 20);
    pc_hold = Pc;
    for (int i = 0; i < 10; i++) begin
      Run = ~Run;
      Zero = ~Zero;
      @(negedge CLK);
      chk("halt_phase", 32'(Phase), 32'd3);
      chk("halt_pc", 32'(Pc), 32'(pc_hold));
      chk("halt_strobes", {29'd0, IR_Load, Acc_Load, Acc_Src}, 32'd0);
    end
`else
    // Single step: a held Step releases exactly one instruction.
    Run = 1'b1;
    repeat (3) @(negedge CLK);
    chk("step_idle_wait", 32'(Phase), 32'd0);
    Step = 1'b1;
    exec_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (Phase == 2'd2) exec_cnt++;
    end
    chk("step1_exec_count", 32'(exec_cnt), 32'd1);
    chk("step1_phase", 32'(Phase), 32'd0);
    chk("step1_pc", 32'(Pc), 32'd1);
    Step = 1'b0;
    repeat (2) @(negedge CLK);
    Step = 1'b1;
    exec_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (Phase == 2'd2) exec_cnt++;
    end
    chk("step2_exec_count", 32'(exec_cnt), 32'd1);
    chk("step2_pc", 32'(Pc), 32'd2);
    Step = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
